// File: rtl/dpram_port_arbiter_pkg.sv
// Shared defaults, state encoding and client indices for the dual-port RAM arbiter.
package dpram_port_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie, the client that did not win last time gets the grant.
module rr_arb2
  import dpram_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_gnt;

  // Reset to client 1 so that client 0 wins the first tie.
  assign gnt0 = en & req0 & (~req1 | (last_gnt == CLIENT1));
  assign gnt1 = en & req1 & (~req0 | (last_gnt == CLIENT0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= CLIENT1;
    end else if (gnt0) begin
      last_gnt <= CLIENT0;
    end else if (gnt1) begin
      last_gnt <= CLIENT1;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Clears the shared dual-port RAM after reset, then arbitrates two R/W clients on port A
// and gates a read-only client onto port B.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  input  logic          rreq_b,
  input  logic [AW-1:0] raddr_b,
  output logic          rgnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          init_busy,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dia,
  input  logic [DW-1:0] ram_doa,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob
);

  // The extra counter bit keeps the terminal compare distinct from a wrapped count.
  localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

  arb_state_t  state;
  logic [AW:0] clr_cnt;

  assign init_busy = (state == ST_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~init_busy),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = addr0;
    ram_dia   = din0;
    if (init_busy) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = clr_cnt[AW-1:0];
      ram_dia   = INIT_VAL;
    end else if (gnt1) begin
      ram_ena   = 1'b1;
      ram_wea   = we1;
      ram_addra = addr1;
      ram_dia   = din1;
    end else if (gnt0) begin
      ram_ena   = 1'b1;
      ram_wea   = we0;
    end
  end

  assign rgnt_b    = rreq_b & ~init_busy;
  assign ram_enb   = rgnt_b;
  assign ram_addrb = raddr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid0  <= gnt0 & ~we0;
      rvalid1  <= gnt1 & ~we1;
      rvalid_b <= rgnt_b;
    end
  end

  // The RAM registers its outputs, so read data lines up with the rvalid pulse.
  assign rdata0  = ram_doa;
  assign rdata1  = ram_doa;
  assign rdata_b = ram_dob;

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Controller that shares the 32x4 dual-port RAM (`raminfr`) between three clients. After reset it clears every RAM word. It then round-robin arbitrates two read/write clients onto RAM port A and gates one read-only client onto port B. It sits directly in front of `raminfr` and drives all of that module's enables, addresses and write data.

## Interface
Parameters:
- AW, 5, address width (depth 2**AW)
- DW, 4, data width
- INIT_VAL, 0, value written to every word during initialisation

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  client 0/1 access request; held with its fields until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  client address
- din0 / din1  in  DW  client write data
- gnt0 / gnt1  out  1  combinational grant; the access is issued to the RAM at the coming clk edge
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata0 / rdata1  out  DW  = ram_doa, meaningful only while the matching rvalid is high
- rreq_b  in  1  port-B read request
- raddr_b  in  AW  port-B address
- rgnt_b  out  1  combinational port-B grant
- rvalid_b  out  1  registered port-B read valid
- rdata_b  out  DW  = ram_dob
- init_busy  out  1  high while the clear sweep runs
- ram_ena, ram_wea, ram_enb  out  1  RAM port controls
- ram_addra, ram_addrb  out  AW  RAM addresses
- ram_dia  out  DW  RAM write data
- ram_doa, ram_dob  in  DW  RAM read data; registered in the RAM, 1-cycle latency

## Operation
- States: INIT and RUN.
- Reset enters INIT with clear counter = 0 and last_gnt = 1, so client 0 wins the first tie.
- INIT:
  - ram_ena = ram_wea = 1, ram_addra = counter, ram_dia = INIT_VAL.
  - counter increments each cycle; after the write to address 2**AW-1, move to RUN.
  - INIT lasts exactly 2**AW cycles.
  - init_busy = 1; gnt0, gnt1 and rgnt_b are all 0.
- RUN, port A:
  - Only one requester: grant it.
  - Both requesting: grant the client ≠ last_gnt.
  - last_gnt updates to the granted client on the grant edge.
  - Granted client's we/addr/din drive ram_wea/ram_addra/ram_dia; ram_ena = gnt0 | gnt1.
  - No request: ram_ena = 0, ram_wea = 0.
- Granted read (we = 0): rvalid of that client goes 1 for exactly the next cycle. Writes never raise rvalid.
- Port B: rgnt_b = rreq_b & ~init_busy; ram_enb = rgnt_b; ram_addrb = raddr_b; rvalid_b = rgnt_b delayed one cycle.
- Same address on A (write) and B (read) in one cycle: B returns the old data (read-first RAM). The arbiter adds no ordering.
- A client may drop req before it is granted; nothing is issued for it.

## Timing
- Reset values:
  - init_busy = 1.
  - ram_ena = ram_wea = 1 and ram_addra = 0 combinationally from the INIT state.
  - All gnt, rgnt_b and rvalid outputs = 0; ram_enb = 0.
- Grant-to-data latency is 1 cycle for both ports.
- Throughput is one port-A access per cycle. Under continuous contention the two clients alternate every cycle.
- rst_n asserted mid-operation, including mid-INIT: immediate return to INIT at counter 0. Pending rvalids clear asynchronously, and the full sweep restarts after release.
- Counter is AW+1 bits so the terminal state is unambiguous; no wrap into RUN early.

## Structure
- Shared package holds:
  - AW and DW defaults.
  - The state encoding: INIT = 1'b0, RUN = 1'b1.
  - The client-index constants.
- One natural sub-module, rr_arb2: a 2-way round-robin arbiter with a last_gnt register.
- INIT sequencing, muxing and rvalid pipeline registers live in the top.
- `raminfr` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then release: init_busy high for exactly 32 cycles, ram_addra steps 0..31 with wea = 1. A subsequent client-0 read of addr 17 returns 4'h0 with rvalid0 one cycle after gnt0.
- Client 0 writes 4'hA to addr 2, then reads addr 2: gnt0 on both; rvalid0 pulses once with rdata0 = 4'hA.
- req0 and req1 held high for 6 cycles: grants go 0,1,0,1,0,1. A later single request from client 1 is granted immediately.
- Port-A write of 4'hC to addr 4 while port B reads addr 4 in the same cycle: rdata_b = old value (0). A port-B re-read next cycle returns 4'hC.
- rreq_b asserted during INIT: rgnt_b = 0 and ram_enb = 0 until init_busy falls, then granted in the first RUN cycle.
- rst_n pulsed low while a client-1 read is pending at cycle 40: rvalid1 cleared, init_busy = 1, sweep restarts at addr 0.
